// File: rtl/vram_slot_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_slot_arbiter_if
// Bundles every non-clock signal of the VRAM slot arbiter: the video timing
// and fetch inputs, the CPU request/ack handshake and the single-port RAM
// bus.
//   slave  : arbiter view (drives video/CPU results and the RAM port)
//   master : environment view (timing generator, CPU, RAM model)
// Signals:
//   clk_pix       pixel enable, one access slot per high clk cycle
//   hc, hbl, vbl  horizontal counter, horizontal/vertical blank
//   vid_addr      video fetch address
//   vid_data      video read data, vid_valid one-clk strobe
//   cpu_req/we/addr/din   CPU request (level, held until ack)
//   cpu_dout/cpu_ack      CPU read data, four-phase acknowledge
//   ram_addr/we/din/dout  synchronous RAM, 1-clk read latency
// ---------------------------------------------------------------------------
interface vram_slot_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          clk_pix;
  logic [8:0]    hc;
  logic          hbl;
  logic          vbl;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  clk_pix, hc, hbl, vbl, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  ram_dout,
    output vid_data, vid_valid, cpu_dout, cpu_ack,
    output ram_addr, ram_we, ram_din
  );

  modport master (
    output clk_pix, hc, hbl, vbl, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output ram_dout,
    input  vid_data, vid_valid, cpu_dout, cpu_ack,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// vram_slot_arbiter
// Time-slices one synchronous single-port VRAM between the video fetch and a
// CPU. Every clk edge with clk_pix=1 is an access slot: even hc -> video,
// odd hc -> CPU. Video reads return on vid_data with a one-clk vid_valid
// strobe two clks after the slot. CPU accesses run a four-phase handshake
// (IDLE -> ISSUE -> CAPTURE -> HOLD), acking two clks after the slot.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    vram_slot_arbiter_if.slave (video, CPU and RAM signals)
// Build option:
//   VRAM_ARB_BLANK_CPU_EN  when defined, every slot during hbl/vbl is a CPU
//                          slot and no video fetch happens in blanking.
// ---------------------------------------------------------------------------
module vram_slot_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  vram_slot_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } cpu_st_e;

  cpu_st_e       st_q;
  logic          wr_q;        // current CPU access is a write
  logic          cpu_ack_q;
  logic [DW-1:0] cpu_dout_q;

  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic          ram_we_q;

  // [0] slot edge, [1] RAM read edge, [2] data presented (vid_valid)
  logic [2:0]    vld_pipe_q;
  logic [DW-1:0] vid_data_q;

  logic blank_cpu;
  logic cpu_slot;
  logic vid_slot;
  logic cpu_go;
  logic unused_in;

`ifdef VRAM_ARB_BLANK_CPU_EN
  assign blank_cpu = bus.hbl | bus.vbl;
  assign unused_in = ^bus.hc[8:1];
`else
  assign blank_cpu = 1'b0;
  assign unused_in = ^{bus.hc[8:1], bus.hbl, bus.vbl};
`endif

  assign cpu_slot = bus.clk_pix & (bus.hc[0] | blank_cpu);
  assign vid_slot = bus.clk_pix & ~cpu_slot;
  // A request is only taken while the FSM is idle; otherwise it stays
  // pending (cpu_req is a level) until a later CPU slot.
  assign cpu_go   = cpu_slot & bus.cpu_req & (st_q == IDLE);

  // RAM port. ram_we is a single-clk pulse: it is cleared on every edge
  // that does not start a write, and slots are never on consecutive edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (vid_slot) begin
        ram_addr_q <= bus.vid_addr;
      end else if (cpu_go) begin
        ram_addr_q <= bus.cpu_addr;
        ram_din_q  <= bus.cpu_din;
        ram_we_q   <= bus.cpu_we;
      end
    end
  end

  // Video capture pipeline, independent of the CPU FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      vid_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], vid_slot};
      if (vld_pipe_q[1]) vid_data_q <= bus.ram_dout;
    end
  end

  // CPU handshake FSM with registered ack/dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= IDLE;
      wr_q       <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (cpu_go) begin
            st_q <= ISSUE;
            wr_q <= bus.cpu_we;
          end
        end
        ISSUE: st_q <= CAPTURE;   // RAM samples the access on this edge
        CAPTURE: begin
          st_q      <= HOLD;
          cpu_ack_q <= 1'b1;
          if (!wr_q) cpu_dout_q <= bus.ram_dout;
        end
        HOLD: begin
          // Also covers a request dropped early: ack then lasts one clk.
          if (!bus.cpu_req) begin
            cpu_ack_q <= 1'b0;
            st_q      <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.vid_valid = vld_pipe_q[2];
  assign bus.vid_data  = vid_data_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_dout  = cpu_dout_q;

endmodule

// File: doc/vram_slot_arbiter.md
VRAM_SLOT_ARBITER -- requirements
Module: vram_slot_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, VRAM address width.
REQ-002 SHALL have parameter DW, default 8, VRAM data width.
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_pix  in  1  pixel enable; one access slot per clk cycle with clk_pix=1; never high on two consecutive clk cycles.
REQ-006 SHALL have port hc  in  9  horizontal pixel counter from the timing generator.
REQ-007 SHALL have port hbl  in  1  horizontal blank; port vbl  in  1  vertical blank.
REQ-008 SHALL have port vid_addr  in  AW  video fetch address.
REQ-009 SHALL have port vid_data  out  DW  video read data; port vid_valid  out  1  one-clk strobe.
REQ-010 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_din in DW (CPU request, level, held until ack).
REQ-011 SHALL have port cpu_dout  out  DW  read data; port cpu_ack  out  1  four-phase acknowledge.
REQ-012 SHALL have ports ram_addr out AW, ram_we out 1, ram_din out DW, ram_dout in DW (synchronous single-port RAM, 1-clk read latency).

Function
REQ-013 SHALL classify each slot (clk edge with clk_pix=1) as video when hc[0]=0, CPU when hc[0]=1.
REQ-014 SHALL, on a video slot, register ram_addr<=vid_addr, ram_we<=0; two clk edges later, vid_data<=ram_dout and vid_valid=1 for exactly one clk.
REQ-015 SHALL run CPU FSM states IDLE, ISSUE, CAPTURE, HOLD.
REQ-016 SHALL, in IDLE on a CPU slot with cpu_req=1, register ram_addr<=cpu_addr, ram_din<=cpu_din, ram_we<=cpu_we; go to ISSUE.
REQ-017 SHALL deassert ram_we on the next clk edge (ram_we high exactly one clk per write).
REQ-018 SHALL go ISSUE->CAPTURE on the next clk edge, then CAPTURE->HOLD on the following edge, setting cpu_ack=1; on reads cpu_dout<=ram_dout, on writes cpu_dout unchanged.
REQ-019 SHALL hold cpu_ack=1 in HOLD until cpu_req=0, then clear cpu_ack and return to IDLE on that edge.
REQ-020 SHALL leave a cpu_req arriving during a video slot pending until the next eligible CPU slot; requests never lost.
REQ-021 SHALL, on CPU slot with cpu_req=0 or FSM not IDLE, leave ram_addr unchanged and ram_we=0 (idle slot).
REQ-022 SHALL complete an access whose cpu_req dropped before ack; cpu_ack then high one clk only.
REQ-023 SHALL keep video capture pipeline independent of CPU FSM; a video slot during ISSUE/CAPTURE is serviced normally.
REQ-024 SHALL make worst-case CPU latency req->ack: 2 slots + 2 clk.

Reset
REQ-025 SHALL, on reset=1, set FSM=IDLE, cpu_ack=0, cpu_dout=0, vid_valid=0, vid_data=0, ram_we=0, ram_addr=0, ram_din=0, pipeline valid bits=0.
REQ-026 SHALL abandon any in-flight access on reset mid-operation; no ack, no ram_we after reset.
REQ-027 SHALL treat first clk after reset release as normal; a clk_pix slot there is honoured.

Configuration
REQ-028 SHALL, with macro VRAM_ARB_BLANK_CPU_EN defined, make every slot a CPU slot while hbl=1 or vbl=1 (no video fetch, vid_valid never pulses in blank).
REQ-029 SHALL, without VRAM_ARB_BLANK_CPU_EN, use the hc[0] split in all regions, including blanking.

Verification
REQ-030 SHALL cover: video slot hc=0x010, vid_addr=0x123, RAM[0x123]=0x5A -> ram_addr=0x123 next clk, vid_data=0x5A with vid_valid 2 clk after slot.
REQ-031 SHALL cover: cpu_req=1 write addr=0x040 din=0xC3 during video slot -> ram_we single clk at next odd-hc slot, RAM[0x040]=0xC3, cpu_ack held until cpu_req=0.
REQ-032 SHALL cover: CPU read addr=0x040 -> cpu_dout=0xC3 with cpu_ack, ack 2 clk after CPU slot edge.
REQ-033 SHALL cover: reset asserted in ISSUE -> cpu_ack stays 0, ram_we=0, FSM IDLE; re-issued request completes normally.
REQ-034 SHALL cover: vbl=1, back-to-back CPU reads -> with VRAM_ARB_BLANK_CPU_EN, accesses on consecutive slots (hc even and odd), vid_valid=0; without it, only odd slots, vid_valid pulses on even.
REQ-035 SHALL cover: cpu_req dropped in ISSUE -> cpu_ack high exactly one clk, FSM IDLE next edge.
